hetszegmens: RTL and testbench



---
 rtl/hetszegmens.sv | 84 ++++++++
 tb/tb_hetszegmens.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hetszegmens.sv
// Two-digit multiplexed driver for a 4-digit common-anode seven-segment
// display. Digit 0 (AN[0]) shows din0 and digit 1 (AN[1]) shows din1. The
// two left-hand digits stay dark. Anodes and segments are active-low.
module hetszegmens #(
    parameter int REFRESH_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    output logic [3:0] AN,
    output logic [7:0] SEG
);

    localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CNT - 1);

    logic [CW-1:0] cnt;
    logic          sel;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;

    // Hex to active-low segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Pick the value of the currently selected digit and decode it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        digit   = din0;
        seg_dec = 7'h7F;
        if (sel) begin
            digit = din1;
        end
        seg_dec = decode(digit);
    end

    // Prescaler: each digit slot lasts REFRESH_CNT clocks, then sel toggles.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst) begin
            cnt <= '0;
            sel <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            sel <= ~sel;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered display outputs; anode and segments always come from the
    // same sel value, so they can never belong to different digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AN  <= 4'b1111;
            SEG <= 8'hFF;
        end else begin
            AN  <= sel ? 4'b1101 : 4'b1110;
            SEG <= {1'b1, seg_dec};
        end
    end

endmodule

// File: tb/tb_hetszegmens.sv
// Directed bench for hetszegmens with a 4-clock refresh slot: reset values,
// basic scan, decode sweep on both digits, unselected-digit change,
// mid-scan reset and a long one-hot/consistency run.
module tb_hetszegmens;

    localparam int RC = 4;

    logic       clk;
    logic       rst;
    logic [3:0] din0;
    logic [3:0] din1;
    logic [3:0] AN;
    logic [7:0] SEG;

    int errors = 0;
    int checks = 0;
    int edges  = 0;   // rising edges since the most recent reset release

    typedef struct {
        logic [3:0] din;
        logic [7:0] seg;
    } vec_t;

    vec_t vecs[16];

    hetszegmens #(.REFRESH_CNT(RC)) dut (
        .clk  (clk),
        .rst  (rst),
        .din0 (din0),
        .din1 (din1),
        .AN   (AN),
        .SEG  (SEG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, edges, $time);
        end
    endtask

    // Advance one clock; outputs are sampled at the following falling edge.
    task automatic tick();
        @(negedge clk);
        edges++;
    endtask

    // Digit driven by the next rising edge: 0 for edges 1..4, 1 for 5..8, ...
    function automatic int next_digit();
        return (edges / RC) % 2;
    endfunction

    // Tick until edges mod 2*RC equals ph (bounded).
    task automatic wait_phase(input int ph);
        int n = 0;
        while ((edges % (2 * RC)) != ph && n < 4 * RC) begin
            tick();
            n++;
        end
        if ((edges % (2 * RC)) != ph) begin
            errors++;
            checks++;
            $display("FAIL wait_phase: phase %0d not reached", ph);
        end
    endtask

    initial begin
        vecs[0]  = '{4'h0, 8'hC0}; vecs[1]  = '{4'h1, 8'hF9};
        vecs[2]  = '{4'h2, 8'hA4}; vecs[3]  = '{4'h3, 8'hB0};
        vecs[4]  = '{4'h4, 8'h99}; vecs[5]  = '{4'h5, 8'h92};
        vecs[6]  = '{4'h6, 8'h82}; vecs[7]  = '{4'h7, 8'hF8};
        vecs[8]  = '{4'h8, 8'h80}; vecs[9]  = '{4'h9, 8'h90};
        vecs[10] = '{4'hA, 8'h88}; vecs[11] = '{4'hB, 8'h83};
        vecs[12] = '{4'hC, 8'hC6}; vecs[13] = '{4'hD, 8'hA1};
        vecs[14] = '{4'hE, 8'h86}; vecs[15] = '{4'hF, 8'h8E};

        // Reset, including before any clock edge.
        rst  = 1'b1;
        din0 = 4'h7;
        din1 = 4'h3;
        #1 rst = 1'b0;
        #1;
        check("reset_an_preclk", {4'h0, AN}, 8'h0F);
        check("reset_seg_preclk", SEG, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_an", {4'h0, AN}, 8'h0F);
            check("reset_seg", SEG, 8'hFF);
        end

        // Basic scan: 4 clocks of digit 0 (7 -> F8), then 4 of digit 1 (3 -> B0).
        rst   = 1'b1;
        edges = 0;
        for (int i = 0; i < 4 * RC; i++) begin
            tick();
            if (((edges - 1) / RC) % 2 == 0) begin
                check("scan_an0", {4'h0, AN}, 8'h0E);
                check("scan_seg0", SEG, 8'hF8);
            end else begin
                check("scan_an1", {4'h0, AN}, 8'h0D);
                check("scan_seg1", SEG, 8'hB0);
            end
        end

        // Decode sweep on digit 0, then digit 1.
        for (int i = 0; i < 16; i++) begin
            wait_phase(0);
            din0 = vecs[i].din;
            tick();
            check("sweep_an0", {4'h0, AN}, 8'h0E);
            check("sweep_seg0", SEG, vecs[i].seg);
        end
        for (int i = 0; i < 16; i++) begin
            wait_phase(RC);
            din1 = vecs[i].din;
            tick();
            check("sweep_an1", {4'h0, AN}, 8'h0D);
            check("sweep_seg1", SEG, vecs[i].seg);
        end

        // Unselected change: din1 3->A during digit 0 is invisible until slot 1.
        din0 = 4'h7;
        din1 = 4'h3;
        wait_phase(0);
        tick();
        check("unsel_first", SEG, 8'hF8);
        din1 = 4'hA;
        for (int i = 1; i < RC; i++) begin
            tick();
            check("unsel_hold", SEG, 8'hF8);
        end
        tick();
        check("unsel_an1", {4'h0, AN}, 8'h0D);
        check("unsel_seg1", SEG, 8'h88);

        // Mid-scan reset in digit 1's slot, asserted away from any clock edge.
        tick();
        #2 rst = 1'b0;
        #1;
        check("midrst_an_async", {4'h0, AN}, 8'h0F);
        check("midrst_seg_async", SEG, 8'hFF);
        tick();
        check("midrst_an_held", {4'h0, AN}, 8'h0F);
        check("midrst_seg_held", SEG, 8'hFF);
        rst   = 1'b1;
        edges = 0;
        for (int i = 0; i < 2 * RC; i++) begin
            tick();
            if (i < RC) begin
                check("restart_an0", {4'h0, AN}, 8'h0E);
                check("restart_seg0", SEG, 8'hF8);
            end else begin
                check("restart_an1", {4'h0, AN}, 8'h0D);
                check("restart_seg1", SEG, 8'h88);
            end
        end

        // Long run with random inputs: AN one-hot on the right digit, SEG matching it.
        for (int i = 0; i < 120; i++) begin
            logic [3:0] exp_an;
            int         d;
            din0   = 4'($urandom_range(0, 15));
            din1   = 4'($urandom_range(0, 15));
            d      = next_digit();
            exp_an = (d == 0) ? 4'b1110 : 4'b1101;
            tick();
            check("onehot_an", {4'h0, AN}, {4'h0, exp_an});
            check("onehot_seg", SEG, vecs[(d == 0) ? din0 : din1].seg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
